// File: rtl/ppu_write_queue.sv
`default_nettype none
// ============================================================================
//  Module   : ppu_write_queue
//  Purpose  : Buffers CPU writes aimed at the ppu tables in a FIFO and
//             releases them to the ppu only inside the vertical-blanking
//             window (or at any time in immediate mode), so table updates
//             never tear mid-frame. A control/status register lives in the
//             otherwise unused ppu address space 2'b11 (0x03xx).
//  Ports    : clk, reset_n           - clock, async active-low reset
//             chipselect/write/read  - Avalon slave strobes
//             address/writedata      - Avalon word address and write data
//             readdata               - status word (combinational, latency 0)
//                                      {pad, ovf, imm, count[AW:0]}
//             vcount                 - current line from the ppu counters
//             ppu_*                  - registered write bus towards the ppu
//  Revision : 1.0  initial release
// ============================================================================
module ppu_write_queue #(
   parameter int DEPTH        = 64,
   parameter int AW           = 6,
   parameter int VBLANK_START = 480,
   parameter int VBLANK_END   = 523
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        chipselect,
   input  logic        write,
   input  logic        read,
   input  logic [15:0] address,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic [9:0]  vcount,
   output logic        ppu_chipselect,
   output logic        ppu_write,
   output logic [15:0] ppu_address,
   output logic [31:0] ppu_writedata
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [9:0]  VB_START   = 10'(VBLANK_START);
   localparam logic [9:0]  VB_END     = 10'(VBLANK_END);
   localparam int          PAD_W      = 32 - (AW + 3);

   // Each entry holds {address, writedata}.
   logic [47:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          imm;
   logic          ovf;

   logic acc;
   logic ctrl;
   logic push;
   logic flush;
   logic full;
   logic push_ok;
   logic win;
   logic pop;

   always_comb begin
      acc     = chipselect & write;
      ctrl    = acc & (address[9:8] == 2'b11);
      push    = acc & ~ctrl;
      flush   = ctrl & writedata[2];
      // Fullness is judged on the pre-edge count, so a push into a full
      // queue is dropped even when a pop frees a slot in the same cycle.
      full    = (count == FULL_COUNT);
      push_ok = push & ~full;
      win     = imm | ((vcount >= VB_START) && (vcount <= VB_END));
      pop     = win & (count != '0) & ~flush;
   end

   // Storage array carries no reset: its contents are only meaningful
   // between rd_ptr and wr_ptr, which are reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= {address, writedata};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         imm            <= 1'b0;
         ovf            <= 1'b0;
         ppu_chipselect <= 1'b0;
         ppu_write      <= 1'b0;
         ppu_address    <= '0;
         ppu_writedata  <= '0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push_ok) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
         end

         if (ctrl) begin
            imm <= writedata[0];
         end

         // A clear and a new overflow cannot share a cycle (single bus port),
         // so the ordering of these two branches is immaterial.
         if (push & full) begin
            ovf <= 1'b1;
         end else if (ctrl & writedata[1]) begin
            ovf <= 1'b0;
         end

         // One-cycle strobe per popped entry; address/data hold otherwise.
         ppu_chipselect <= pop;
         ppu_write      <= pop;
         if (pop) begin
            {ppu_address, ppu_writedata} <= mem[rd_ptr];
         end
      end
   end

   assign readdata = (chipselect & read) ? {{PAD_W{1'b0}}, ovf, imm, count} : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_ppu_write_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ppu_write_queue
//  Purpose  : Self-checking bench for ppu_write_queue. A queue-based model
//             predicts the ppu strobe stream and the status word every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ppu_write_queue;

   logic        clk;
   logic        reset_n;
   logic        chipselect;
   logic        write;
   logic        read;
   logic [15:0] address;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [9:0]  vcount;
   logic        ppu_chipselect;
   logic        ppu_write;
   logic [15:0] ppu_address;
   logic [31:0] ppu_writedata;

   ppu_write_queue #(
      .DEPTH        (64),
      .AW           (6),
      .VBLANK_START (480),
      .VBLANK_END   (523)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .chipselect     (chipselect),
      .write          (write),
      .read           (read),
      .address        (address),
      .writedata      (writedata),
      .readdata       (readdata),
      .vcount         (vcount),
      .ppu_chipselect (ppu_chipselect),
      .ppu_write      (ppu_write),
      .ppu_address    (ppu_address),
      .ppu_writedata  (ppu_writedata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: plain queue of {address, data} plus the two flags.
   logic [47:0] mq[$];
   bit          m_imm;
   bit          m_ovf;

   // Observed / expected values of the most recent cycle.
   logic        obs_stb, obs_cs, exp_stb;
   logic [15:0] obs_addr, exp_addr;
   logic [31:0] obs_data, exp_data;
   logic [31:0] obs_rd, exp_rd;

   localparam logic [15:0] CTRL_ADDR = 16'h0300;

   // Drive one bus cycle, advance the model across the edge, sample outputs.
   task automatic cyc(input bit cs, input bit wr, input bit rd,
                      input logic [15:0] a, input logic [31:0] d, input logic [9:0] vc);
      bit m_acc, m_ctrl, m_push, m_flush, m_win, m_pop, m_full;
      @(negedge clk);
      chipselect = cs;
      write      = wr;
      read       = rd;
      address    = a;
      writedata  = d;
      vcount     = vc;
      #1;
      obs_rd = readdata;
      exp_rd = (cs && rd) ? {23'b0, m_ovf, m_imm, 7'(mq.size())} : 32'd0;
      m_acc   = cs && wr;
      m_ctrl  = m_acc && (a[9:8] == 2'b11);
      m_push  = m_acc && !m_ctrl;
      m_flush = m_ctrl && d[2];
      m_full  = (mq.size() == 64);
      m_win   = m_imm || (vc >= 10'd480 && vc <= 10'd523);
      m_pop   = m_win && (mq.size() != 0) && !m_flush;
      exp_stb = m_pop;
      if (m_pop) begin
         exp_addr = mq[0][47:32];
         exp_data = mq[0][31:0];
         void'(mq.pop_front());
      end
      if (m_push) begin
         if (m_full) m_ovf = 1'b1;
         else        mq.push_back({a, d});
      end
      if (m_ctrl) begin
         m_imm = d[0];
         if (d[1]) m_ovf = 1'b0;
         if (d[2]) mq.delete();
      end
      @(posedge clk);
      #1;
      obs_stb  = ppu_write;
      obs_cs   = ppu_chipselect;
      obs_addr = ppu_address;
      obs_data = ppu_writedata;
   endtask

   task automatic test_reset();
      chipselect = 1'b1; write = 1'b0; read = 1'b1;
      address = '0; writedata = '0; vcount = '0;
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      #3;
      checks++;
      if (ppu_write !== 1'b0 || ppu_chipselect !== 1'b0 || ppu_address !== 16'h0 ||
          ppu_writedata !== 32'h0 || readdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: wr=%b cs=%b addr=%h data=%h rd=%h, required all zero",
                  ppu_write, ppu_chipselect, ppu_address, ppu_writedata, readdata);
      end
      mq.delete(); m_imm = 0; m_ovf = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      cyc(1, 0, 1, 16'h0, 32'h0, 10'd100);
      checks++;
      if (obs_rd !== exp_rd || obs_stb !== 1'b0) begin
         errors++;
         $display("FAIL reset_status: readdata=%h stb=%b, required readdata=%h stb=0", obs_rd, obs_stb, exp_rd);
      end
   endtask

   task automatic test_basic();
      logic [15:0] ta [3];
      logic [31:0] td [3];
      int seen;
      ta[0] = 16'h0001; td[0] = 32'hAABBCCDD;
      ta[1] = 16'h0105; td[1] = 32'h00000001;
      ta[2] = 16'h0203; td[2] = 32'h00FF0000;
      for (int i = 0; i < 6; i++) begin
         if (i < 3) cyc(1, 1, 0, ta[i], td[i], 10'd100);
         else       cyc(0, 0, 0, 16'h0, 32'h0, 10'd100);
         checks++;
         if (obs_stb !== 1'b0 || obs_cs !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: stb=%b cs=%b outside window, required 0", obs_stb, obs_cs);
         end
      end
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 0, 16'h0, 32'h0, 10'd480);
         checks++;
         if (obs_stb !== exp_stb || obs_cs !== exp_stb ||
             (exp_stb && (obs_addr !== ta[seen] || obs_data !== td[seen]))) begin
            errors++;
            $display("FAIL basic_drain: stb=%b cs=%b addr=%h data=%h, required stb=%b addr=%h data=%h",
                     obs_stb, obs_cs, obs_addr, obs_data, exp_stb, exp_addr, exp_data);
         end
         if (obs_stb === 1'b1 && seen < 2) seen++;
         else if (obs_stb === 1'b1) seen = 3;
      end
      checks++;
      if (seen != 3) begin
         errors++;
         $display("FAIL basic_count: strobes=%0d, required 3", seen);
      end
      cyc(1, 0, 1, 16'h0, 32'h0, 10'd480);
      checks++;
      if (obs_rd !== exp_rd) begin
         errors++;
         $display("FAIL basic_status: readdata=%h, required %h", obs_rd, exp_rd);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 65; i++) begin
         cyc(1, 1, 0, {8'h00, 8'(i)}, $urandom, 10'd0);
         checks++;
         if (obs_stb !== 1'b0) begin
            errors++;
            $display("FAIL ovf_fill: stb=%b at push %0d, required 0", obs_stb, i);
         end
      end
      cyc(1, 0, 1, 16'h0, 32'h0, 10'd0);
      checks++;
      if (obs_rd !== exp_rd || obs_rd !== 32'h0000_0140) begin
         errors++;
         $display("FAIL ovf_status: readdata=%h, required %h", obs_rd, exp_rd);
      end
      cyc(1, 1, 0, CTRL_ADDR, 32'h2, 10'd0);
      cyc(1, 0, 1, 16'h0, 32'h0, 10'd0);
      checks++;
      if (obs_rd !== exp_rd || obs_rd !== 32'h0000_0040) begin
         errors++;
         $display("FAIL ovf_clear: readdata=%h, required %h", obs_rd, exp_rd);
      end
      cyc(1, 1, 0, CTRL_ADDR, 32'h4, 10'd0);
      cyc(1, 0, 1, 16'h0, 32'h0, 10'd480);
      checks++;
      if (obs_rd !== exp_rd || obs_stb !== 1'b0) begin
         errors++;
         $display("FAIL ovf_flush: readdata=%h stb=%b, required %h stb=0", obs_rd, obs_stb, exp_rd);
      end
   endtask

   task automatic test_imm();
      cyc(1, 1, 0, CTRL_ADDR, 32'h1, 10'd200);
      cyc(1, 1, 0, 16'h0007, 32'h12345678, 10'd200);
      checks++;
      if (obs_stb !== 1'b0) begin
         errors++;
         $display("FAIL imm_edge_k: stb=%b, required 0", obs_stb);
      end
      cyc(0, 0, 0, 16'h0, 32'h0, 10'd200);
      checks++;
      if (obs_stb !== 1'b1 || obs_cs !== 1'b1 || obs_addr !== 16'h0007 ||
          obs_data !== 32'h12345678 || exp_stb !== 1'b1) begin
         errors++;
         $display("FAIL imm_forward: stb=%b cs=%b addr=%h data=%h, required stb=1 addr=0007 data=12345678",
                  obs_stb, obs_cs, obs_addr, obs_data);
      end
      cyc(1, 1, 0, CTRL_ADDR, 32'h0, 10'd200);
      checks++;
      if (obs_stb !== 1'b0) begin
         errors++;
         $display("FAIL imm_single: stb=%b, required 0", obs_stb);
      end
   endtask

   task automatic test_window_edge();
      int seen;
      for (int i = 0; i < 10; i++) cyc(1, 1, 0, {8'h10, 8'(i)}, $urandom, 10'd0);
      for (int i = 0; i < 7; i++) begin
         cyc(0, 0, 0, 16'h0, 32'h0, (i < 2) ? 10'd523 : 10'd524);
         checks++;
         if (obs_stb !== exp_stb || obs_cs !== exp_stb ||
             (exp_stb && (obs_addr !== exp_addr || obs_data !== exp_data))) begin
            errors++;
            $display("FAIL window_edge: cycle %0d stb=%b addr=%h data=%h, required stb=%b addr=%h data=%h",
                     i, obs_stb, obs_addr, obs_data, exp_stb, exp_addr, exp_data);
         end
      end
      cyc(1, 0, 1, 16'h0, 32'h0, 10'd524);
      checks++;
      if (obs_rd !== exp_rd || obs_rd[6:0] !== 7'd8) begin
         errors++;
         $display("FAIL window_count: readdata=%h, required %h", obs_rd, exp_rd);
      end
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(0, 0, 0, 16'h0, 32'h0, 10'd480);
         if (obs_stb === 1'b1) seen++;
         checks++;
         if (obs_stb !== exp_stb || obs_cs !== exp_stb ||
             (exp_stb && (obs_addr !== exp_addr || obs_data !== exp_data))) begin
            errors++;
            $display("FAIL window_resume: cycle %0d stb=%b addr=%h data=%h, required stb=%b addr=%h data=%h",
                     i, obs_stb, obs_addr, obs_data, exp_stb, exp_addr, exp_data);
         end
      end
      checks++;
      if (seen != 8) begin
         errors++;
         $display("FAIL window_resume_count: strobes=%0d, required 8", seen);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) cyc(1, 1, 0, {8'h20, 8'(i)}, $urandom, 10'd0);
      for (int i = 0; i < 80; i++) begin
         if (i < 70) cyc(1, 1, 1, {8'h21, 8'(i)}, $urandom, 10'd490);
         else        cyc(1, 0, 1, 16'h0, 32'h0, 10'd490);
         checks++;
         if (obs_stb !== exp_stb || obs_cs !== exp_stb || obs_rd !== exp_rd ||
             (exp_stb && (obs_addr !== exp_addr || obs_data !== exp_data))) begin
            errors++;
            $display("FAIL back_to_back: cycle %0d stb=%b addr=%h data=%h rd=%h, required stb=%b addr=%h data=%h rd=%h",
                     i, obs_stb, obs_addr, obs_data, obs_rd, exp_stb, exp_addr, exp_data, exp_rd);
         end
      end
   endtask

   task automatic test_random();
      logic [9:0]  vlist [10];
      logic [15:0] a;
      logic [31:0] d;
      int          r;
      vlist[0] = 10'd0;   vlist[1] = 10'd100; vlist[2] = 10'd479; vlist[3] = 10'd480;
      vlist[4] = 10'd481; vlist[5] = 10'd500; vlist[6] = 10'd522; vlist[7] = 10'd523;
      vlist[8] = 10'd524; vlist[9] = 10'd1023;
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         a = 16'($urandom);
         d = $urandom;
         if (a[9:8] == 2'b11) a[9] = 1'b0;
         if (r < 45)      cyc(1, 1, 0, a, d, vlist[$urandom_range(0, 9)]);
         else if (r < 50) cyc(1, 1, 0, CTRL_ADDR | {8'h00, a[7:0]},
                              {29'b0, ($urandom_range(0, 3) == 0), d[1:0]},
                              vlist[$urandom_range(0, 9)]);
         else if (r < 70) cyc(1, 0, 1, a, d, vlist[$urandom_range(0, 9)]);
         else             cyc(r[0], 0, 0, a, d, vlist[$urandom_range(0, 9)]);
         checks++;
         if (obs_stb !== exp_stb || obs_cs !== exp_stb || obs_rd !== exp_rd ||
             (exp_stb && (obs_addr !== exp_addr || obs_data !== exp_data))) begin
            errors++;
            $display("FAIL random: cycle %0d stb=%b addr=%h data=%h rd=%h, required stb=%b addr=%h data=%h rd=%h",
                     i, obs_stb, obs_addr, obs_data, obs_rd, exp_stb, exp_addr, exp_data, exp_rd);
         end
      end
   endtask

   task automatic test_flush_reset();
      cyc(1, 1, 0, CTRL_ADDR, 32'h4, 10'd0);
      for (int i = 0; i < 4; i++) cyc(1, 1, 0, {8'h30, 8'(i)}, $urandom, 10'd0);
      cyc(1, 1, 0, CTRL_ADDR, 32'h4, 10'd480);
      for (int i = 0; i < 5; i++) begin
         cyc(1, 0, 1, 16'h0, 32'h0, 10'd480);
         checks++;
         if (obs_stb !== 1'b0 || exp_stb !== 1'b0 || obs_rd !== exp_rd) begin
            errors++;
            $display("FAIL flush: cycle %0d stb=%b rd=%h, required stb=0 rd=%h", i, obs_stb, obs_rd, exp_rd);
         end
      end
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, {8'h31, 8'(i)}, $urandom, 10'd0);
      cyc(0, 0, 0, 16'h0, 32'h0, 10'd480);
      checks++;
      if (obs_stb !== 1'b1 || exp_stb !== 1'b1 || obs_addr !== exp_addr) begin
         errors++;
         $display("FAIL pre_reset_strobe: stb=%b addr=%h, required stb=1 addr=%h", obs_stb, obs_addr, exp_addr);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (ppu_write !== 1'b0 || ppu_chipselect !== 1'b0 || ppu_address !== 16'h0 || ppu_writedata !== 32'h0) begin
         errors++;
         $display("FAIL async_reset: wr=%b cs=%b addr=%h data=%h, required all zero",
                  ppu_write, ppu_chipselect, ppu_address, ppu_writedata);
      end
      chipselect = 1'b1; write = 1'b0; read = 1'b1;
      #1;
      checks++;
      if (readdata !== 32'h0) begin
         errors++;
         $display("FAIL async_reset_status: readdata=%h, required 0", readdata);
      end
      mq.delete(); m_imm = 0; m_ovf = 0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 16'h0, 32'h0, 10'd480);
         checks++;
         if (obs_stb !== 1'b0 || exp_stb !== 1'b0) begin
            errors++;
            $display("FAIL reset_lost_queue: stb=%b, required 0", obs_stb);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_imm();
      test_window_edge();
      test_back_to_back();
      test_random();
      test_flush_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
